// File: rtl/key_scheduler_pkg.sv
// Shared types and default sizing for the arcfour key-search scheduler.
package ks_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ks_state_t;

    localparam int unsigned            KS_KEY_BITS = 24;
    localparam logic [KS_KEY_BITS-1:0] KS_KEY_MAX  = 24'h3FFFFF;

endpackage

// File: rtl/key_scheduler_rr_arbiter.sv
// Round-robin picker: first requesting, unmasked core at or after the pointer.
module rr_arbiter #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] pointer,
    output logic [N-1:0]         grant
);

    localparam int unsigned IW = $clog2(N);

    logic             taken;
    logic [IW-1:0]    sel;
    int unsigned      idx;

    always_comb begin
        grant = '0;
        taken = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(pointer) + i) % N;
            sel = IW'(idx);
            if (!taken && req[sel] && !mask[sel]) begin
                grant[sel] = 1'b1;
                taken      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_scheduler.sv
// Hands out sequential key candidates to arcfour cores and collects the winning hit.
module key_scheduler
    import ks_pkg::*;
#(
    parameter int unsigned         NUM_CORES = 8,
    parameter int unsigned         KEY_BITS  = KS_KEY_BITS,
    parameter logic [KEY_BITS-1:0] KEY_MAX   = KEY_BITS'(KS_KEY_MAX)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NUM_CORES-1:0]         req,
    input  logic [NUM_CORES-1:0]         done,
    input  logic [NUM_CORES-1:0]         hit,
    output logic [NUM_CORES-1:0]         grant,
    output logic [KEY_BITS-1:0]          key_out,
    output logic                         kill,
    output logic                         busy,
    output logic                         finished,
    output logic                         success,
    output logic [KEY_BITS-1:0]          found_key,
    output logic [$clog2(NUM_CORES)-1:0] found_core
);

    localparam int unsigned IW = $clog2(NUM_CORES);

    ks_state_t            state;
    logic [KEY_BITS-1:0]  counter;
    logic [IW-1:0]        pointer;
    logic [NUM_CORES-1:0] outstanding;
    logic [KEY_BITS-1:0]  core_key [NUM_CORES];

    logic [NUM_CORES-1:0] arb_grant;
    logic [NUM_CORES-1:0] win_vec;
    logic [NUM_CORES-1:0] out_after_done;
    logic [IW-1:0]        gnt_idx;
    logic [IW-1:0]        hit_idx;
    logic [IW-1:0]        ii;
    logic                 any_hit;

    assign win_vec        = done & hit & outstanding;
    assign out_after_done = outstanding & ~done;

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .req     (req),
        .mask    (outstanding),
        .pointer (pointer),
        .grant   (arb_grant)
    );

    // Lowest-index hit wins when several cores report in the same cycle.
    always_comb begin
        gnt_idx = '0;
        hit_idx = '0;
        any_hit = 1'b0;
        ii      = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            ii = IW'(i);
            if (arb_grant[ii]) gnt_idx = ii;
            if (win_vec[ii] && !any_hit) begin
                any_hit = 1'b1;
                hit_idx = ii;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant       <= '0;
            key_out     <= '0;
            kill        <= 1'b1;
            busy        <= 1'b0;
            finished    <= 1'b0;
            success     <= 1'b0;
            found_key   <= '0;
            found_core  <= '0;
            counter     <= '0;
            pointer     <= '0;
            outstanding <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) core_key[i] <= '0;
        end else begin
            grant <= '0;
            if (abort) begin
                state       <= IDLE;
                outstanding <= '0;
                kill        <= 1'b1;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state       <= RUN;
                            counter     <= '0;
                            outstanding <= '0;
                            pointer     <= '0;
                            finished    <= 1'b0;
                            success     <= 1'b0;
                            kill        <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                    RUN, DRAIN: begin
                        // A hit pre-empts both draining and any grant due this cycle.
                        if (any_hit) begin
                            state       <= DONE;
                            found_key   <= core_key[hit_idx];
                            found_core  <= hit_idx;
                            success     <= 1'b1;
                            finished    <= 1'b1;
                            kill        <= 1'b1;
                            busy        <= 1'b0;
                            outstanding <= out_after_done;
                        end else if (state == DRAIN) begin
                            outstanding <= out_after_done;
                            if (out_after_done == '0) begin
                                state    <= DONE;
                                finished <= 1'b1;
                                success  <= 1'b0;
                                kill     <= 1'b1;
                                busy     <= 1'b0;
                            end
                        end else begin
                            outstanding <= out_after_done | arb_grant;
                            if (arb_grant != '0) begin
                                grant             <= arb_grant;
                                key_out           <= counter;
                                counter           <= counter + 1'b1;
                                core_key[gnt_idx] <= counter;
                                pointer <= (gnt_idx == IW'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
                                if (counter == KEY_MAX) state <= DRAIN;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_scheduler.sv
// Directed bench: instance A (large key space) and B (KEY_MAX=5) share all inputs.
module tb_key_scheduler;

    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic [3:0] req, done, hit;

    logic [3:0]  a_grant, b_grant;
    logic [23:0] a_key, b_key, a_fkey, b_fkey;
    logic        a_kill, a_busy, a_fin, a_succ;
    logic        b_kill, b_busy, b_fin, b_succ;
    logic [1:0]  a_fcore, b_fcore;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_scheduler #(.NUM_CORES(4)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .req(req), .done(done), .hit(hit),
        .grant(a_grant), .key_out(a_key), .kill(a_kill), .busy(a_busy),
        .finished(a_fin), .success(a_succ), .found_key(a_fkey), .found_core(a_fcore)
    );

    key_scheduler #(.NUM_CORES(4), .KEY_MAX(24'd5)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .req(req), .done(done), .hit(hit),
        .grant(b_grant), .key_out(b_key), .kill(b_kill), .busy(b_busy),
        .finished(b_fin), .success(b_succ), .found_key(b_fkey), .found_core(b_fcore)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_grant(input string tag, input logic [3:0] eg, input logic [23:0] ek);
        chk({tag, "_grant"}, 32'(a_grant), 32'(eg));
        chk({tag, "_key"},   32'(a_key),   32'(ek));
    endtask

    task automatic chk_b_grant(input string tag, input logic [3:0] eg, input logic [23:0] ek);
        chk({tag, "_grant"}, 32'(b_grant), 32'(eg));
        chk({tag, "_key"},   32'(b_key),   32'(ek));
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_grant"},  32'(a_grant), 32'h0);
        chk({tag, "_key"},    32'(a_key),   32'h0);
        chk({tag, "_kill"},   32'(a_kill),  32'h1);
        chk({tag, "_busy"},   32'(a_busy),  32'h0);
        chk({tag, "_fin"},    32'(a_fin),   32'h0);
        chk({tag, "_succ"},   32'(a_succ),  32'h0);
        chk({tag, "_fkey"},   32'(a_fkey),  32'h0);
        chk({tag, "_fcore"},  32'(a_fcore), 32'h0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        req = '0; done = '0; hit = '0;
        tick(); tick();
        chk_a_reset("rst");
        chk("rst_b_kill", 32'(b_kill), 32'h1);
        reset = 1'b1;

        // Four requesting cores are granted keys 0..3 back to back.
        start = 1'b1; tick(); start = 1'b0;
        chk("run_busy", 32'(a_busy), 32'h1);
        chk("run_kill", 32'(a_kill), 32'h0);
        req = 4'b1111;
        tick(); chk_a_grant("g0", 4'b0001, 24'd0);
        tick(); chk_a_grant("g1", 4'b0010, 24'd1);
        tick(); chk_a_grant("g2", 4'b0100, 24'd2);
        tick(); chk_a_grant("g3", 4'b1000, 24'd3);
        tick(); chk("all_out_grant", 32'(a_grant), 32'h0);

        // Cores 0..2 finish without a hit and get keys 4..6.
        done = 4'b0111; tick(); done = '0;
        chk("done_cycle_grant", 32'(a_grant), 32'h0);
        tick(); chk_a_grant("g4", 4'b0001, 24'd4);
        tick(); chk_a_grant("g5", 4'b0010, 24'd5);
        tick(); chk_a_grant("g6", 4'b0100, 24'd6);

        // Core 2 hits on key 6.
        req = '0; done = 4'b0100; hit = 4'b0100;
        tick(); done = '0; hit = '0;
        chk("hit_succ",  32'(a_succ),  32'h1);
        chk("hit_fin",   32'(a_fin),   32'h1);
        chk("hit_fkey",  32'(a_fkey),  32'd6);
        chk("hit_fcore", 32'(a_fcore), 32'd2);
        chk("hit_kill",  32'(a_kill),  32'h1);
        chk("hit_busy",  32'(a_busy),  32'h0);

        // start and abort together: abort wins, sticky results kept.
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(a_busy), 32'h0);
        chk("sa_kill", 32'(a_kill), 32'h1);
        chk("sa_fin",  32'(a_fin),  32'h1);
        chk("sa_succ", 32'(a_succ), 32'h1);

        // Simultaneous hits on cores 1 and 3: core 1 wins.
        start = 1'b1; tick(); start = 1'b0;
        chk("rs_fin", 32'(a_fin), 32'h0);
        req = 4'b1111;
        tick(); chk_a_grant("s0", 4'b0001, 24'd0);
        chk_b_grant("bs0", 4'b0001, 24'd0);
        tick(); tick(); tick(); chk_a_grant("s3", 4'b1000, 24'd3);
        req = '0; done = 4'b1010; hit = 4'b1010;
        tick(); done = '0; hit = '0;
        chk("dual_fcore", 32'(a_fcore), 32'd1);
        chk("dual_fkey",  32'(a_fkey),  32'd1);
        chk("dual_succ",  32'(a_succ),  32'h1);

        // Abort with three cores outstanding.
        start = 1'b1; tick(); start = 1'b0;
        req = 4'b1111;
        tick(); chk_a_grant("ab0", 4'b0001, 24'd0);
        tick(); chk_a_grant("ab1", 4'b0010, 24'd1);
        tick(); chk_a_grant("ab2", 4'b0100, 24'd2);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ab_grant", 32'(a_grant), 32'h0);
        chk("ab_kill",  32'(a_kill),  32'h1);
        chk("ab_busy",  32'(a_busy),  32'h0);
        tick(); chk("ab_idle_grant", 32'(a_grant), 32'h0);
        start = 1'b1; tick(); start = 1'b0;
        tick(); chk_a_grant("ab_regrant", 4'b0001, 24'd0);
        req = '0;

        // Instance B exhausts keys 0..5 and drains.
        abort = 1'b1; tick(); abort = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        req = 4'b1111;
        tick(); chk_b_grant("x0", 4'b0001, 24'd0);
        tick(); chk_b_grant("x1", 4'b0010, 24'd1);
        tick(); chk_b_grant("x2", 4'b0100, 24'd2);
        tick(); chk_b_grant("x3", 4'b1000, 24'd3);
        done = 4'b1111; tick(); done = '0;
        chk("x_done_grant", 32'(b_grant), 32'h0);
        tick(); chk_b_grant("x4", 4'b0001, 24'd4);
        tick(); chk_b_grant("x5", 4'b0010, 24'd5);
        chk("x_drain_busy", 32'(b_busy), 32'h1);
        tick(); chk("x_drain_grant", 32'(b_grant), 32'h0);
        chk("x_drain_fin", 32'(b_fin), 32'h0);
        req = '0; done = 4'b0011; tick(); done = '0;
        chk("x_fin",  32'(b_fin),  32'h1);
        chk("x_succ", 32'(b_succ), 32'h0);
        chk("x_busy", 32'(b_busy), 32'h0);
        chk("x_kill", 32'(b_kill), 32'h1);

        // Asynchronous reset while A is still running.
        req = 4'b1111; tick();
        chk("pre_rst_busy", 32'(a_busy), 32'h1);
        #2 reset = 1'b0;
        #1 chk_a_reset("async");
        #3 reset = 1'b1;
        tick(); chk("post_rst_grant", 32'(a_grant), 32'h0);
        chk("post_rst_kill", 32'(a_kill), 32'h1);
        req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_scheduler.md
KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 8: number of arcfour cores served.
REQ-002 Parameter KEY_BITS, default 24: key-candidate width.
REQ-003 Parameter KEY_MAX, default 24'h3FFFFF: last candidate in the search space, inclusive.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a search from key 0.
REQ-007 abort  in  1  one-cycle pulse; terminates any search.
REQ-008 req  in  NUM_CORES  per-core level request for a new candidate.
REQ-009 done  in  NUM_CORES  per-core one-cycle pulse; candidate evaluated.
REQ-010 hit  in  NUM_CORES  qualifies done; candidate decrypted to valid plaintext.
REQ-011 grant  out  NUM_CORES  one-hot, one-cycle; core accepts key_out.
REQ-012 key_out  out  KEY_BITS  candidate, valid only while grant is non-zero.
REQ-013 kill  out  1  hold-in-reset to all cores.
REQ-014 busy  out  1  high in RUN or DRAIN.
REQ-015 finished  out  1  sticky; search ended (found or exhausted).
REQ-016 success  out  1  sticky; search ended with a hit.
REQ-017 found_key  out  KEY_BITS  winning candidate; valid while success.
REQ-018 found_core  out  $clog2(NUM_CORES)  index of the winning core.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE->RUN on start: clear key counter, outstanding mask, finished, success; arbiter pointer to core 0.
REQ-021 In RUN, at most one grant per cycle, to a requesting core whose outstanding bit is clear, chosen round-robin from the pointer.
REQ-022 After a grant to core n, the pointer SHALL move to n+1 modulo NUM_CORES.
REQ-023 Same cycle as grant: key_out = counter; counter increments; core's assigned key stored; outstanding bit set.
REQ-024 Grant latency SHALL be one cycle: req sampled at edge k yields grant in cycle k+1.
REQ-025 req from an outstanding core SHALL be ignored.
REQ-026 done from core n SHALL clear outstanding bit n; done from a non-outstanding core SHALL be ignored.
REQ-027 Grant of key KEY_MAX SHALL cause RUN->DRAIN; no further grants.
REQ-028 DRAIN->DONE when the outstanding mask is zero; finished=1, success=0.
REQ-029 done&hit on an outstanding core in RUN or DRAIN SHALL cause ->DONE; found_key = that core's stored key; found_core = index; success=1; finished=1.
REQ-030 Simultaneous hits: lowest core index wins.
REQ-031 Hit and a pending grant in the same cycle: hit wins, no grant issued.
REQ-032 kill SHALL be high in IDLE and DONE, low in RUN and DRAIN.
REQ-033 start in RUN/DRAIN SHALL be ignored; start in DONE restarts as from IDLE.
REQ-034 abort in any state SHALL go to IDLE; finished, success unchanged; outstanding cleared.
REQ-035 start and abort in the same cycle: abort wins.

Reset
REQ-036 Reset SHALL force IDLE, grant=0, key_out=0, kill=1, busy=0, finished=0, success=0, found_key=0, found_core=0, counter=0, pointer=0, outstanding=0.
REQ-037 Reset mid-search SHALL discard all state; no grant may appear in the first cycle after release.

Structure
REQ-038 Package ks_pkg SHALL hold the state enum and the default KEY_BITS/KEY_MAX constants.
REQ-039 Round-robin selection SHALL be a sub-module rr_arbiter (req, mask, pointer -> one-hot grant).
REQ-040 Per-core assigned-key storage SHALL be a register array, not RAM.

Verification
REQ-041 NUM_CORES=4, all req high after start -> grants to cores 0,1,2,3 with key_out 0,1,2,3 in consecutive cycles.
REQ-042 Core 2 done&hit while holding key 6 -> next cycle success=1, found_key=6, found_core=2, kill=1.
REQ-043 KEY_MAX=5, no hits -> six grants, DRAIN, then finished=1, success=0 after the last done.
REQ-044 Cores 1 and 3 hit in the same cycle -> found_core=1.
REQ-045 abort in RUN with 3 outstanding -> IDLE, kill=1, no further grants; a later start regrants key 0.
REQ-046 reset asserted mid-RUN -> all outputs at reset values asynchronously, before the next edge.
